// File: rtl/fifo_dual_reader_pkg.sv
// Shared constants for the dual-port line-FIFO reader: default widths and the
// block-RAM read latency from which the per-channel read credit is derived.
package fifo_dual_reader_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16 * 8;
  localparam int FRAME_LEN_DEFAULT  = 2560;
  localparam int BRAM_RD_LATENCY    = 1;
  // One buffered beat plus one beat still in the RAM pipeline.
  localparam int CREDIT_LIMIT       = BRAM_RD_LATENCY + 1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_reader_channel.sv
// One reader channel: credit-limited read issue, 1-cycle capture, 2-entry skid
// buffer presented as a valid/ready stream, and a frame beat counter for last.
module fifo_reader_channel
  import fifo_dual_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FRAME_LEN  = FRAME_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  empty_i,
  input  logic                  wr_en_i,
  output logic                  rd_en_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  ready_i
);

  localparam int            CW       = cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         beat_q, beat_d;
  logic                  pop, push, rd_en;
  logic [2:0]            committed;

  assign pop  = valid_q & ready_i;
  assign push = inflight_q;

  // A pop in this cycle frees its slot immediately, so a streaming consumer
  // sees one beat per cycle while occupancy still never exceeds two.
  assign committed = {1'b0, occ_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign rd_en     = ~empty_i & ~wr_en_i & (committed < 3'(CREDIT_LIMIT));
  assign rd_en_o   = rd_en & rst_n;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = rd_data_i;
        else               tail_d = rd_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = rd_data_i;
        end else begin
          head_d = tail_q;
          tail_d = rd_data_i;
        end
      end
      default: ;
    endcase
    if (pop) beat_d = (beat_q == LAST_IDX) ? '0 : beat_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rd_en;
      valid_q    <= (occ_d != 2'd0);
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = valid_q;
  assign last_o  = valid_q & (beat_q == LAST_IDX);

endmodule

// File: rtl/fifo_dual_reader.sv
// Consumer-side controller for the one-write/two-read line FIFO: two identical,
// independent reader channels sharing the write-blocking signal.
module fifo_dual_reader
  import fifo_dual_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FRAME_LEN  = FRAME_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_a,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_b,
  input  logic                  fifo_empty_a,
  input  logic                  fifo_empty_b,
  input  logic                  fifo_wr_en,
  output logic                  fifo_rd_en_a,
  output logic                  fifo_rd_en_b,
  output logic [DATA_WIDTH-1:0] out_data_a,
  output logic                  out_valid_a,
  output logic                  out_last_a,
  input  logic                  out_ready_a,
  output logic [DATA_WIDTH-1:0] out_data_b,
  output logic                  out_valid_b,
  output logic                  out_last_b,
  input  logic                  out_ready_b
);

  fifo_reader_channel #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_LEN  (FRAME_LEN)
  ) u_chan_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_data_i (fifo_rd_data_a),
    .empty_i   (fifo_empty_a),
    .wr_en_i   (fifo_wr_en),
    .rd_en_o   (fifo_rd_en_a),
    .data_o    (out_data_a),
    .valid_o   (out_valid_a),
    .last_o    (out_last_a),
    .ready_i   (out_ready_a)
  );

  fifo_reader_channel #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_LEN  (FRAME_LEN)
  ) u_chan_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_data_i (fifo_rd_data_b),
    .empty_i   (fifo_empty_b),
    .wr_en_i   (fifo_wr_en),
    .rd_en_o   (fifo_rd_en_b),
    .data_o    (out_data_b),
    .valid_o   (out_valid_b),
    .last_o    (out_last_b),
    .ready_i   (out_ready_b)
  );

endmodule
